// File: rtl/ctrl_pkg.sv
// Shared control types for the RV32I pipeline control carrier: decoder bundle,
// opcode constants, forwarding select encoding and operand-use helpers.
package ctrl_pkg;

  localparam int CTRL_ALU_OPW = 3;

  typedef struct packed {
    logic                    reg_write;
    logic                    is_imm;
    logic                    mem_read;
    logic                    mem_write;
    logic                    mem_to_reg;
    logic [CTRL_ALU_OPW-1:0] alu_op;
    logic                    jump;
    logic                    branch;
    logic                    U_type;
  } ctrl_t;

  localparam logic [6:0] OP_R     = 7'd51;
  localparam logic [6:0] OP_I     = 7'd19;
  localparam logic [6:0] OP_L     = 7'd3;
  localparam logic [6:0] OP_S     = 7'd35;
  localparam logic [6:0] OP_JAL   = 7'd111;
  localparam logic [6:0] OP_JALR  = 7'd103;
  localparam logic [6:0] OP_B     = 7'd99;
  localparam logic [6:0] OP_LUI   = 7'd55;
  localparam logic [6:0] OP_AUIPC = 7'd23;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  function automatic logic uses_rs1(input logic [6:0] opcode);
    return !(opcode == OP_JAL || opcode == OP_LUI || opcode == OP_AUIPC);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OP_R || opcode == OP_S || opcode == OP_B);
  endfunction

  function automatic logic is_known(input logic [6:0] opcode);
    return (opcode == OP_R   || opcode == OP_I   || opcode == OP_L   ||
            opcode == OP_S   || opcode == OP_JAL || opcode == OP_JALR ||
            opcode == OP_B   || opcode == OP_LUI || opcode == OP_AUIPC);
  endfunction

endpackage

// File: rtl/ctrl_pipe_stage.sv
// One pipeline control register (valid, ctrl bundle, rd, rs1, rs2).
// bubble_i loads an empty slot: valid, ctrl and register fields all zero.
module ctrl_stage_reg
  import ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bubble_i,
  input  logic              valid_i,
  input  ctrl_t             ctrl_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  output logic              valid_o,
  output ctrl_t             ctrl_o,
  output logic [REG_AW-1:0] rd_o,
  output logic [REG_AW-1:0] rs1_o,
  output logic [REG_AW-1:0] rs2_o
);

  logic              valid_d, valid_q;
  ctrl_t             ctrl_d, ctrl_q;
  logic [REG_AW-1:0] rd_d, rd_q, rs1_d, rs1_q, rs2_d, rs2_q;

  always_comb begin
    valid_d = valid_i;
    ctrl_d  = ctrl_i;
    rd_d    = rd_i;
    rs1_d   = rs1_i;
    rs2_d   = rs2_i;
    if (bubble_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      rd_d    = '0;
      rs1_d   = '0;
      rs2_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      rd_q    <= rd_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign rd_o    = rd_q;
  assign rs1_o   = rs1_q;
  assign rs2_o   = rs2_q;

endmodule

// File: rtl/ctrl_pipe.sv
// Pipeline control carrier: moves decoder control through ID/EX, EX/MEM and
// MEM/WB, detects load-use hazards, drives stall/flush/redirect and EX forwarding.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int ALU_OPW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [6:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  ctrl_t             id_ctrl,
  input  logic              ex_taken,
  output logic              stall,
  output logic              flush,
  output logic              redirect,
  output logic              ex_valid,
  output ctrl_t             ex_ctrl,
  output logic [REG_AW-1:0] ex_rd,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mem_valid,
  output ctrl_t             mem_ctrl,
  output logic [REG_AW-1:0] mem_rd,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [REG_AW-1:0] wb_rd
);

  if (ALU_OPW != CTRL_ALU_OPW) begin : g_alu_opw_check
    $error("ctrl_pipe: ALU_OPW must equal the ctrl_t alu_op width");
  end

  logic              id_valid_eff;
  logic [REG_AW-1:0] id_rs1_use, id_rs2_use;
  logic              load_use, idex_bubble;
  logic [REG_AW-1:0] ex_rs1, ex_rs2, mem_rs1, mem_rs2, wb_rs1, wb_rs2;
  logic              wb_valid;
  ctrl_t             wb_ctrl;
  logic              unused_wb;

  // Unused source fields are carried as x0 so they can never match a producer.
  always_comb begin
    id_valid_eff = id_valid & is_known(id_opcode);
    id_rs1_use   = (id_valid_eff && uses_rs1(id_opcode)) ? id_rs1 : '0;
    id_rs2_use   = (id_valid_eff && uses_rs2(id_opcode)) ? id_rs2 : '0;
  end

  always_comb begin
    redirect    = ex_valid & (ex_ctrl.jump | (ex_ctrl.branch & ex_taken));
    load_use    = ex_valid & ex_ctrl.mem_read & (ex_rd != '0) & id_valid_eff &
                  ((id_rs1_use == ex_rd) | (id_rs2_use == ex_rd));
    stall       = load_use & ~redirect;
    flush       = redirect;
    idex_bubble = stall | redirect | ~id_valid_eff;
  end

  function automatic logic prod_hit(input logic vld, input logic rw,
                                    input logic [REG_AW-1:0] rd,
                                    input logic [REG_AW-1:0] rs);
    return vld & rw & (rd != '0) & (rd == rs);
  endfunction

  function automatic fwd_sel_t pick_fwd(input logic [REG_AW-1:0] rs,
                                        input logic m_vld, input logic m_rw,
                                        input logic [REG_AW-1:0] m_rd,
                                        input logic w_vld, input logic w_rw,
                                        input logic [REG_AW-1:0] w_rd);
    if (prod_hit(m_vld, m_rw, m_rd, rs)) return FWD_MEM;
    if (prod_hit(w_vld, w_rw, w_rd, rs)) return FWD_WB;
    return FWD_RF;
  endfunction

  always_comb begin
    fwd_a = pick_fwd(ex_rs1, mem_valid, mem_ctrl.reg_write, mem_rd,
                     wb_valid, wb_ctrl.reg_write, wb_rd);
    fwd_b = pick_fwd(ex_rs2, mem_valid, mem_ctrl.reg_write, mem_rd,
                     wb_valid, wb_ctrl.reg_write, wb_rd);
  end

  ctrl_stage_reg #(.REG_AW(REG_AW)) u_id_ex (
    .clk(clk), .rst_n(rst_n), .bubble_i(idex_bubble),
    .valid_i(id_valid_eff), .ctrl_i(id_ctrl), .rd_i(id_rd),
    .rs1_i(id_rs1_use), .rs2_i(id_rs2_use),
    .valid_o(ex_valid), .ctrl_o(ex_ctrl), .rd_o(ex_rd),
    .rs1_o(ex_rs1), .rs2_o(ex_rs2)
  );

  ctrl_stage_reg #(.REG_AW(REG_AW)) u_ex_mem (
    .clk(clk), .rst_n(rst_n), .bubble_i(1'b0),
    .valid_i(ex_valid), .ctrl_i(ex_ctrl), .rd_i(ex_rd),
    .rs1_i(ex_rs1), .rs2_i(ex_rs2),
    .valid_o(mem_valid), .ctrl_o(mem_ctrl), .rd_o(mem_rd),
    .rs1_o(mem_rs1), .rs2_o(mem_rs2)
  );

  ctrl_stage_reg #(.REG_AW(REG_AW)) u_mem_wb (
    .clk(clk), .rst_n(rst_n), .bubble_i(1'b0),
    .valid_i(mem_valid), .ctrl_i(mem_ctrl), .rd_i(mem_rd),
    .rs1_i(mem_rs1), .rs2_i(mem_rs2),
    .valid_o(wb_valid), .ctrl_o(wb_ctrl), .rd_o(wb_rd),
    .rs1_o(wb_rs1), .rs2_o(wb_rs2)
  );

  assign wb_reg_write  = wb_valid & wb_ctrl.reg_write;
  assign wb_mem_to_reg = wb_valid & wb_ctrl.mem_to_reg;
  assign unused_wb     = ^{wb_ctrl, wb_rs1, wb_rs2};

endmodule
